turbo_dec_8bit: RTL
===================

// Module: turbo_dec_8bit
// PURPOSE
//  Receive side of the 8-bit turbo link. Accepts a 2-byte frame: data byte, then parity byte
//   {parity1[3:0], parity2[3:0]}. parity1 is computed on the data; parity2 on the bit-reversed data.
//  Recomputes both parities and forms an 8-bit syndrome. Corrects any single-bit error in the
//   16-bit codeword, flags anything else as uncorrectable, and returns the data byte with a status.
//  Sits between the link byte port and the consumer logic.
// PARAMETERS
//  CNT_W  8  width of the saturating error counters (used only with TURBO_DEC_STATS_EN)
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      in_byte valid
//  in_byte     in   8      frame byte: first data, then parity
//  in_ready    out  1      decoder can accept in_byte
//  out_valid   out  1      decoded result valid; held until out_ready
//  out_ready   in   1      consumer accepts result
//  out_data    out  8      corrected (or raw, if uncorrectable) data byte
//  out_status  out  2      00 clean, 01 data bit fixed, 10 parity bit fixed, 11 uncorrectable
//  corr_cnt    out  CNT_W  (TURBO_DEC_STATS_EN only) count of frames with status 01 or 10
//  unc_cnt     out  CNT_W  (TURBO_DEC_STATS_EN only) count of frames with status 11
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_status=00, counters=0.
//   Reset applies mid-frame or mid-search; the partial frame is discarded.
//  Byte transfer: occurs on a clock edge where in_valid && in_ready. in_ready=1 only in IDLE and WAIT_PAR.
//  Parity function P(d)[3:0]:
//   P0=d0^d1^d2, P1=d2^d3^d4, P2=d4^d5^d6, P3=d6^d7^d0.
//   rev(d)[i]=d[7-i].
//  Syndrome: S = par_rx ^ {P(data), P(rev(data))}.
//  Data-bit signature: SIG(i) = {P(1<<i), P(1<<(7-i))}, i=0..7.
//   All eight are distinct, each with weight >= 2.
//  FSM:
//   IDLE: transfer -> latch data, WAIT_PAR.
//   WAIT_PAR: transfer -> latch parity, CHECK.
//   CHECK (1 cycle): S==0 -> OUT status 00.
//    popcount(S)==1 -> OUT status 10; data unchanged.
//    else -> SEARCH with idx=0.
//   SEARCH: one idx per cycle.
//    S==SIG(idx) -> data^=(1<<idx); OUT status 01.
//    else if idx==7 -> OUT status 11; data raw.
//    else idx++.
//   OUT: out_valid=1; out_data/out_status stable.
//    out_ready -> IDLE; out_valid drops the next cycle.
//  Latency, counted from the edge E that accepts the parity byte:
//   out_valid is high after edge E+1 for status 00/10.
//   After E+2+i for a fix of data bit i.
//   After E+9 for uncorrectable.
//  No bypass: in_ready stays 0 through CHECK, SEARCH and OUT. The next data byte is accepted no
//   earlier than the edge after the out handshake.
//  in_valid while in_ready=0 is ignored; the byte must be held by the sender.
// CONFIGURATION
//  TURBO_DEC_STATS_EN defined:
//   corr_cnt/unc_cnt ports exist.
//   Each increments by 1 on the edge entering OUT with the matching status.
//   Each saturates at 2^CNT_W-1 and clears only on rst.
//  Not defined: ports and counters absent. All other behaviour is identical.
// STRUCTURE
//  Package turbo_pkg:
//   function parity4(d[7:0]) -> [3:0]; function bitrev8.
//   function sig(idx) -> [7:0].
//   localparams ST_* (IDLE, WAIT_PAR, CHECK, SEARCH, OUT); STAT_CLEAN/FIXD/FIXP/UNC.
//  Sub-module turbo_dec_syn: combinational data+parity -> S[7:0], s_zero, s_weight1.
//  Top holds the FSM, search index, data/parity registers and the optional counters.
// TESTING
//  Clean: 0xA5, 0x66 -> out_data 0xA5, status 00, out_valid after E+1.
//  Data fix: 0xAD, 0x66 -> out_data 0xA5, status 01, out_valid after E+5 (bit 3).
//  Parity fix: 0xA5, 0x67 -> out_data 0xA5, status 10, out_valid after E+1.
//  Double error: 0xA6, 0x66 (S=0x84) -> out_data 0xA6, status 11, out_valid after E+9.
//  Backpressure and reset:
//   out_ready=0 for 5 cycles -> out_valid/out_data held; in_ready=0 throughout.
//   rst pulse during SEARCH -> out_valid=0, in_ready=1; the next frame 0x00, 0x00 gives status 00.
//  Stats (TURBO_DEC_STATS_EN, CNT_W=2): 5 data-fix frames -> corr_cnt saturates at 3; unc_cnt=0.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the 8-bit turbo link receive decoder.
//   - FSM state encodings (ST_*) and the state_t enum built on them
//   - result status codes (STAT_*)
//   - parity4 : 4-bit parity of a data byte
//   - bitrev8 : bit reversal of a byte
//   - sig     : 8-bit syndrome produced by a single error on data bit idx
package turbo_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_PAR = 3'd1;
  localparam logic [2:0] ST_CHECK    = 3'd2;
  localparam logic [2:0] ST_SEARCH   = 3'd3;
  localparam logic [2:0] ST_OUT      = 3'd4;

  localparam logic [1:0] STAT_CLEAN = 2'b00;
  localparam logic [1:0] STAT_FIXD  = 2'b01;
  localparam logic [1:0] STAT_FIXP  = 2'b10;
  localparam logic [1:0] STAT_UNC   = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_PAR = ST_WAIT_PAR,
    CHECK    = ST_CHECK,
    SEARCH   = ST_SEARCH,
    OUT      = ST_OUT
  } state_t;

  // Each parity bit covers three adjacent data bits, wrapping at the top.
  function automatic logic [3:0] parity4(input logic [7:0] d);
    logic [3:0] p;
    p[0] = d[0] ^ d[1] ^ d[2];
    p[1] = d[2] ^ d[3] ^ d[4];
    p[2] = d[4] ^ d[5] ^ d[6];
    p[3] = d[6] ^ d[7] ^ d[0];
    return p;
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[7-i];
    end
    return r;
  endfunction

  // Parity is linear, so a lone flip of data bit idx yields exactly the
  // parities of the one-hot byte (and of its reversal).
  function automatic logic [7:0] sig(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'd1 << idx;
    return {parity4(one), parity4(bitrev8(one))};
  endfunction

endpackage

// File: rtl/turbo_dec_syn.sv
// Combinational syndrome generator for the turbo decoder.
// Ports:
//   i_data      in  8  received data byte
//   i_par       in  8  received parity byte {parity1, parity2}
//   o_syn       out 8  syndrome = received parity ^ recomputed parity
//   o_s_zero    out 1  syndrome is all zero (frame clean)
//   o_s_weight1 out 1  syndrome has exactly one bit set (parity bit error)
module turbo_dec_syn
  import turbo_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [7:0] i_par,
  output logic [7:0] o_syn,
  output logic       o_s_zero,
  output logic       o_s_weight1
);

  logic [7:0] w_par_calc;

  assign w_par_calc  = {parity4(i_data), parity4(bitrev8(i_data))};
  assign o_syn       = i_par ^ w_par_calc;
  assign o_s_zero    = (o_syn == 8'd0);
  assign o_s_weight1 = $onehot(o_syn);

endmodule

// File: rtl/turbo_dec_8bit.sv
// Receive-side decoder for the 8-bit turbo link.
// Takes a two-byte frame (data, then {parity1, parity2}), corrects any single
// bit error in the 16-bit codeword, and presents the data byte with a status.
// Optional statistics counters are enabled by defining TURBO_DEC_STATS_EN.
// Ports:
//   clk        in   1      clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      in_byte valid
//   in_byte    in   8      frame byte: data first, then parity
//   in_ready   out  1      decoder can accept in_byte (IDLE / WAIT_PAR only)
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   out_data   out  8      corrected (or raw, if uncorrectable) data byte
//   out_status out  2      00 clean, 01 data fixed, 10 parity fixed, 11 uncorrectable
//   corr_cnt   out  CNT_W  (TURBO_DEC_STATS_EN) saturating count of corrected frames
//   unc_cnt    out  CNT_W  (TURBO_DEC_STATS_EN) saturating count of uncorrectable frames
module turbo_dec_8bit
  import turbo_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [1:0]       out_status
`ifdef TURBO_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] unc_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("turbo_dec_8bit: CNT_W must be at least 1");
  end

  state_t     r_state;
  logic [7:0] r_data;
  logic [7:0] r_par;
  logic [2:0] r_idx;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_out_data;
  logic [1:0] r_out_status;

  logic [7:0] w_syn;
  logic       w_s_zero;
  logic       w_s_weight1;
  logic       w_xfer;
  logic       w_fin;
  logic [1:0] w_fin_status;
  logic [7:0] w_fin_data;

  turbo_dec_syn u_syn (
    .i_data      (r_data),
    .i_par       (r_par),
    .o_syn       (w_syn),
    .o_s_zero    (w_s_zero),
    .o_s_weight1 (w_s_weight1)
  );

  assign w_xfer = in_valid && r_in_ready;

  // Decision for the current cycle: does the frame finish (enter OUT) now,
  // and with what data/status. Shared by the FSM and the counters.
  always_comb begin
    w_fin        = 1'b0;
    w_fin_status = STAT_CLEAN;
    w_fin_data   = r_data;
    if (r_state == CHECK) begin
      if (w_s_zero) begin
        w_fin        = 1'b1;
        w_fin_status = STAT_CLEAN;
      end else if (w_s_weight1) begin
        w_fin        = 1'b1;
        w_fin_status = STAT_FIXP;
      end
    end else if (r_state == SEARCH) begin
      if (w_syn == sig(r_idx)) begin
        w_fin        = 1'b1;
        w_fin_status = STAT_FIXD;
        w_fin_data   = r_data ^ (8'd1 << r_idx);
      end else if (r_idx == 3'd7) begin
        w_fin        = 1'b1;
        w_fin_status = STAT_UNC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_data       <= 8'd0;
      r_par        <= 8'd0;
      r_idx        <= 3'd0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_status <= STAT_CLEAN;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_data  <= in_byte;
            r_state <= WAIT_PAR;
          end
        end
        WAIT_PAR: begin
          if (w_xfer) begin
            r_par      <= in_byte;
            r_in_ready <= 1'b0;
            r_state    <= CHECK;
          end
        end
        CHECK, SEARCH: begin
          if (w_fin) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_fin_data;
            r_out_status <= w_fin_status;
            r_state      <= OUT;
          end else if (r_state == CHECK) begin
            r_idx   <= 3'd0;
            r_state <= SEARCH;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_status = r_out_status;

`ifdef TURBO_DEC_STATS_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_unc_cnt;

  // Counters bump on the edge that enters OUT and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
    end else if (w_fin) begin
      if ((w_fin_status == STAT_FIXD || w_fin_status == STAT_FIXP) && !(&r_corr_cnt)) begin
        r_corr_cnt <= r_corr_cnt + 1'b1;
      end
      if (w_fin_status == STAT_UNC && !(&r_unc_cnt)) begin
        r_unc_cnt <= r_unc_cnt + 1'b1;
      end
    end
  end

  assign corr_cnt = r_corr_cnt;
  assign unc_cnt  = r_unc_cnt;
`endif

endmodule
